// File: rtl/multi_sensor_poller_pkg.sv
// Shared definitions for the multi-sensor poller: FSM state encoding, default
// settle/timeout lengths and a helper that sizes the shared poll timer.
package poller_pkg;

    localparam int DEF_SETTLE_CYCLES  = 16;
    localparam int DEF_TIMEOUT_CYCLES = 1024;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        SETTLE,
        WAIT,
        STORE,
        NEXT
    } pollState_t;

    // Enough bits to hold (max(a,b) - 1), never narrower than one bit.
    function automatic int timerWidth(input int a, input int b);
        int m;
        m = (a > b) ? a : b;
        return (m > 1) ? $clog2(m) : 1;
    endfunction

endpackage

// File: rtl/multi_sensor_poller_if.sv
// Handshake between the poller (master) and the serial sensor reader (slave).
interface multi_sensor_poller_if #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8
);
    logic              StartReading;
    logic [ADDR_W-1:0] CurAddr;
    logic [DATA_W-1:0] RecData;
    logic              Done;

    modport master (output StartReading, CurAddr, input RecData, Done);
    modport slave  (input StartReading, CurAddr, output RecData, Done);
endinterface

// File: rtl/multi_sensor_poller_timer.sv
// poll_timer: clearable up-counter with a terminal-count flag, shared by the
// settle and wait phases of the poller.
module poll_timer #(
    parameter int WIDTH = 4
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic             clear,
    input  logic             enable,
    input  logic [WIDTH-1:0] limit,
    output logic             terminal
);

    logic [WIDTH-1:0] count;

    always_ff @(posedge Clock) begin
        if (Reset) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable) begin
            count <= count + WIDTH'(1);
        end
    end

    assign terminal = (count == limit);

endmodule

// File: rtl/multi_sensor_poller.sv
// Round-robin poller that asks a serial reader for one reading per channel.
// Define POLLER_TIMEOUT_EN to give up on a channel that never answers.
module multi_sensor_poller
    import poller_pkg::*;
#(
    parameter int NUM_CH         = 2,
    parameter int DATA_W         = 8,
    parameter int ADDR_W         = 8,
    parameter int SETTLE_CYCLES  = DEF_SETTLE_CYCLES,
    parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
    input  logic                     Clock,
    input  logic                     Reset,
    input  logic                     Start,
    input  logic [NUM_CH*ADDR_W-1:0] ChipAddr,
    multi_sensor_poller_if.master    reader,
    output logic [NUM_CH*DATA_W-1:0] Temps,
    output logic [NUM_CH-1:0]        Valid,
    output logic                     ScanDone,
    output logic                     Busy
);

    localparam int IDX_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int CNT_W = timerWidth(SETTLE_CYCLES, TIMEOUT_CYCLES);

    pollState_t                state, nextState;
    logic [IDX_W-1:0]          index, nextIndex;
    logic [ADDR_W-1:0]         curAddr, nextCurAddr;
    logic [DATA_W-1:0]         capData, nextCapData;
    logic [NUM_CH*DATA_W-1:0]  nextTemps;
    logic [NUM_CH-1:0]         nextValid;
    logic                      nextScanDone;
    logic                      startReading;
    logic                      timerClear, timerEnable, timerTerminal;
    logic [CNT_W-1:0]          timerLimit;

    poll_timer #(.WIDTH(CNT_W)) timer (
        .Clock    (Clock),
        .Reset    (Reset),
        .clear    (timerClear),
        .enable   (timerEnable),
        .limit    (timerLimit),
        .terminal (timerTerminal)
    );

    assign reader.StartReading = startReading;
    assign reader.CurAddr      = curAddr;

    // State and every output are registered; StartReading and Busy are
    // derived from the state being entered so they line up with it exactly.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            state        <= IDLE;
            index        <= '0;
            curAddr      <= '0;
            capData      <= '0;
            Temps        <= '0;
            Valid        <= '0;
            ScanDone     <= 1'b0;
            Busy         <= 1'b0;
            startReading <= 1'b0;
        end else begin
            state        <= nextState;
            index        <= nextIndex;
            curAddr      <= nextCurAddr;
            capData      <= nextCapData;
            Temps        <= nextTemps;
            Valid        <= nextValid;
            ScanDone     <= nextScanDone;
            Busy         <= (nextState != IDLE);
            startReading <= (nextState == SETTLE);
        end
    end

    // Next-state logic; the timer is cleared on entry to SETTLE and WAIT so
    // each phase counts from zero against its own limit.
    always_comb begin
        nextState    = state;
        nextIndex    = index;
        nextCurAddr  = curAddr;
        nextCapData  = capData;
        nextTemps    = Temps;
        nextValid    = Valid;
        nextScanDone = 1'b0;
        timerClear   = 1'b0;
        timerEnable  = 1'b0;
        timerLimit   = CNT_W'(SETTLE_CYCLES - 1);

        case (state)
            IDLE: begin
                if (Start) begin
                    nextIndex = '0;
                    nextState = LOAD;
                end
            end
            LOAD: begin
                nextCurAddr = ChipAddr[index*ADDR_W +: ADDR_W];
                timerClear  = 1'b1;
                nextState   = SETTLE;
            end
            SETTLE: begin
                if (timerTerminal) begin
                    timerClear = 1'b1;
                    nextState  = WAIT;
                end else begin
                    timerEnable = 1'b1;
                end
            end
            WAIT: begin
`ifdef POLLER_TIMEOUT_EN
                timerLimit  = CNT_W'(TIMEOUT_CYCLES - 1);
                timerEnable = 1'b1;
                if (reader.Done) begin
                    nextCapData = reader.RecData;
                    nextState   = STORE;
                end else if (timerTerminal) begin
                    nextValid[index] = 1'b0;
                    nextState        = NEXT;
                end
`else
                if (reader.Done) begin
                    nextCapData = reader.RecData;
                    nextState   = STORE;
                end
`endif
            end
            STORE: begin
                nextTemps[index*DATA_W +: DATA_W] = capData;
                nextValid[index]                  = 1'b1;
                nextState                         = NEXT;
            end
            NEXT: begin
                if (index == IDX_W'(NUM_CH - 1)) begin
                    nextIndex    = '0;
                    nextScanDone = 1'b1;
                    nextState    = Start ? LOAD : IDLE;
                end else begin
                    nextIndex = index + IDX_W'(1);
                    nextState = LOAD;
                end
            end
            default: nextState = IDLE;
        endcase
    end

endmodule

// File: tb/tb_multi_sensor_poller.sv
// Scoreboard bench for multi_sensor_poller: a behavioural sensor reader feeds
// random readings, a reference model predicts each completed scan.
module tb_multi_sensor_poller;

    localparam int NUM_CH  = 4;
    localparam int DATA_W  = 8;
    localparam int ADDR_W  = 8;
    localparam int SETTLE  = 16;
    localparam int TIMEOUT = 32;

    logic                     Clock;
    logic                     Reset;
    logic                     Start;
    logic [NUM_CH*ADDR_W-1:0] ChipAddr;
    logic [NUM_CH*DATA_W-1:0] Temps;
    logic [NUM_CH-1:0]        Valid;
    logic                     ScanDone;
    logic                     Busy;

    multi_sensor_poller_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) pollBus ();

    multi_sensor_poller #(
        .NUM_CH         (NUM_CH),
        .DATA_W         (DATA_W),
        .ADDR_W         (ADDR_W),
        .SETTLE_CYCLES  (SETTLE),
        .TIMEOUT_CYCLES (TIMEOUT)
    ) dut (
        .Clock    (Clock),
        .Reset    (Reset),
        .Start    (Start),
        .ChipAddr (ChipAddr),
        .reader   (pollBus),
        .Temps    (Temps),
        .Valid    (Valid),
        .ScanDone (ScanDone),
        .Busy     (Busy)
    );

    int checks = 0;
    int errors = 0;
    int scanCount = 0;
    logic [NUM_CH*DATA_W+NUM_CH-1:0] expQ[$];

    logic [DATA_W-1:0] modelTemps[NUM_CH];
    logic              modelValid[NUM_CH];
    logic [ADDR_W-1:0] addrTab[NUM_CH];

    int rdRunLen, rdWaitCnt, rdDelay, rdGapCnt, rdExpGap, chPtr;
    bit rdWaiting, rdSilent, inWait, holdReply;
`ifdef POLLER_TIMEOUT_EN
    bit silentCh1, lateCh2;
`endif

    initial begin
        Clock = 1'b0;
        forever #5 Clock = ~Clock;
    end

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s actual %0h required %0h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input logic st, input logic rs);
        @(posedge Clock);
        #1;
        Start = st;
        Reset = rs;
    endtask

    task automatic waitScans(input int target);
        int cyc;
        cyc = 0;
        while (scanCount < target && cyc < 5000) begin
            @(negedge Clock);
            cyc++;
        end
        checkOutput("scan_progress", 64'(scanCount >= target), 64'(1));
    endtask

    // A channel is finished: advance the model's channel pointer and, at the
    // end of a scan, predict what Temps/Valid must show at ScanDone.
    task automatic finishChannel(input int gap);
        logic [NUM_CH*DATA_W-1:0] t;
        logic [NUM_CH-1:0]        v;
        rdWaiting = 1'b0;
        inWait    = 1'b0;
        rdGapCnt  = 0;
        if (chPtr == NUM_CH - 1) begin
            for (int k = 0; k < NUM_CH; k++) begin
                t[k*DATA_W +: DATA_W] = modelTemps[k];
                v[k]                  = modelValid[k];
            end
            expQ.push_back({t, v});
            chPtr    = 0;
            rdExpGap = -1;
        end else begin
            chPtr++;
            rdExpGap = gap;
        end
    endtask

    // Behavioural sensor reader: measures each StartReading burst, answers
    // after a random delay, and occasionally pokes Done during settling.
    initial begin : reader
        logic [DATA_W-1:0] d;
        rdRunLen = 0; rdWaitCnt = 0; rdDelay = 0; rdGapCnt = 0; rdExpGap = -1;
        chPtr = 0; rdWaiting = 0; rdSilent = 0; inWait = 0;
        pollBus.Done    = 1'b0;
        pollBus.RecData = '0;
        forever begin
            @(negedge Clock);
            pollBus.Done = 1'b0;
            rdGapCnt++;
            if (Reset) begin
                rdRunLen = 0; rdWaiting = 0; inWait = 0; chPtr = 0; rdExpGap = -1;
                for (int k = 0; k < NUM_CH; k++) begin
                    modelTemps[k] = '0;
                    modelValid[k] = 1'b0;
                end
            end else if (pollBus.StartReading) begin
                rdRunLen++;
                if (rdRunLen == 1) begin
                    checkOutput("settle_while_waiting", 64'(rdWaiting), 64'(0));
                    checkOutput("cur_addr", 64'(pollBus.CurAddr), 64'(addrTab[chPtr]));
                    if (rdExpGap >= 0)
                        checkOutput("channel_gap", 64'(rdGapCnt), 64'(rdExpGap));
                end
                if (rdRunLen == 5 && $urandom_range(0, 1) == 1) begin
                    pollBus.Done    = 1'b1;
                    pollBus.RecData = DATA_W'($urandom);
                end
            end else begin
                if (rdRunLen != 0) begin
                    checkOutput("settle_len", 64'(rdRunLen), 64'(SETTLE));
                    rdRunLen  = 0;
                    rdWaiting = 1'b1;
                    inWait    = 1'b1;
                    rdWaitCnt = 0;
                    rdDelay   = holdReply ? 20 : int'($urandom_range(0, 6));
                    rdSilent  = 1'b0;
`ifdef POLLER_TIMEOUT_EN
                    if (silentCh1 && chPtr == 1) rdSilent = 1'b1;
                    if (lateCh2 && chPtr == 2) rdDelay = TIMEOUT - 1;
`endif
                end
                if (rdWaiting) begin
                    if (!rdSilent && rdWaitCnt == rdDelay) begin
                        d = DATA_W'($urandom);
                        pollBus.Done    = 1'b1;
                        pollBus.RecData = d;
                        modelTemps[chPtr] = d;
                        modelValid[chPtr] = 1'b1;
                        finishChannel(4);
                    end else if (rdSilent && rdWaitCnt == TIMEOUT - 1) begin
                        modelValid[chPtr] = 1'b0;
                        finishChannel(3);
                    end
                    rdWaitCnt++;
                end
            end
        end
    end

    // Monitor: every ScanDone pulse is matched against the oldest prediction.
    initial begin : monitor
        logic                            prevDone;
        logic [NUM_CH*DATA_W+NUM_CH-1:0] e;
        prevDone = 1'b0;
        forever begin
            @(negedge Clock);
            if (ScanDone) begin
                scanCount++;
                checkOutput("scan_done_width", 64'(prevDone), 64'(0));
                checkOutput("scan_expected_pending", 64'(expQ.size() > 0), 64'(1));
                if (expQ.size() > 0) begin
                    e = expQ.pop_front();
                    checkOutput("scan_temps", 64'(Temps), 64'(e[NUM_CH*DATA_W+NUM_CH-1:NUM_CH]));
                    checkOutput("scan_valid", 64'(Valid), 64'(e[NUM_CH-1:0]));
                end
            end
            prevDone = ScanDone;
        end
    end

    task automatic checkAllZero(input string tag);
        checkOutput({tag, "_busy"}, 64'(Busy), 64'(0));
        checkOutput({tag, "_start_reading"}, 64'(pollBus.StartReading), 64'(0));
        checkOutput({tag, "_cur_addr"}, 64'(pollBus.CurAddr), 64'(0));
        checkOutput({tag, "_temps"}, 64'(Temps), 64'(0));
        checkOutput({tag, "_valid"}, 64'(Valid), 64'(0));
        checkOutput({tag, "_scan_done"}, 64'(ScanDone), 64'(0));
    endtask

    initial begin : stimulus
        int               cyc;
        int               base;
        logic [ADDR_W-1:0] a;
        Reset     = 1'b1;
        Start     = 1'b0;
        holdReply = 1'b0;
`ifdef POLLER_TIMEOUT_EN
        silentCh1 = 1'b0;
        lateCh2   = 1'b0;
`endif
        for (int k = 0; k < NUM_CH; k++) begin
            a      = ADDR_W'($urandom);
            a[2:0] = k[2:0];
            addrTab[k] = a;
            ChipAddr[k*ADDR_W +: ADDR_W] = a;
        end

        repeat (3) @(posedge Clock);
        @(negedge Clock);
        checkAllZero("reset");

        applyStimulus(1'b0, 1'b0);
        repeat (5) @(negedge Clock);
        checkOutput("idle_hold_busy", 64'(Busy), 64'(0));
        checkOutput("idle_hold_start_reading", 64'(pollBus.StartReading), 64'(0));

        applyStimulus(1'b1, 1'b0);
        waitScans(3);

`ifdef POLLER_TIMEOUT_EN
        waitScans(scanCount + 1);
        silentCh1 = 1'b1;
        lateCh2   = 1'b1;
        waitScans(scanCount + 1);
        silentCh1 = 1'b0;
        lateCh2   = 1'b0;
        waitScans(scanCount + 1);
`endif

        // Drop Start while channel 0 of a fresh scan is settling.
        cyc = 0;
        while (!(chPtr == 0 && pollBus.StartReading) && cyc < 2000) begin
            @(negedge Clock);
            cyc++;
        end
        checkOutput("found_channel0_settle", 64'(pollBus.StartReading), 64'(1));
        base = scanCount;
        applyStimulus(1'b0, 1'b0);
        cyc = 0;
        while (Busy && cyc < 2000) begin
            @(negedge Clock);
            cyc++;
        end
        @(negedge Clock);
        checkOutput("idle_after_drop", 64'(Busy), 64'(0));
        checkOutput("scans_after_drop", 64'(scanCount - base), 64'(1));
        repeat (4) @(negedge Clock);
        checkOutput("stays_idle", 64'(Busy), 64'(0));

        // Reset while the reader is deliberately slow to answer.
        holdReply = 1'b1;
        applyStimulus(1'b1, 1'b0);
        cyc = 0;
        while (!(inWait && rdDelay == 20) && cyc < 2000) begin
            @(negedge Clock);
            cyc++;
        end
        checkOutput("found_wait", 64'(inWait), 64'(1));
        applyStimulus(1'b1, 1'b1);
        @(posedge Clock);
        @(negedge Clock);
        checkAllZero("reset_in_wait");
        holdReply = 1'b0;
        applyStimulus(1'b1, 1'b0);
        cyc = 0;
        while (!pollBus.StartReading && cyc < 100) begin
            @(negedge Clock);
            cyc++;
        end
        checkOutput("restart_settle", 64'(pollBus.StartReading), 64'(1));
        checkOutput("restart_addr", 64'(pollBus.CurAddr), 64'(addrTab[0]));
        checkOutput("restart_valid", 64'(Valid), 64'(0));
        waitScans(scanCount + 2);

        applyStimulus(1'b0, 1'b0);
        cyc = 0;
        while (Busy && cyc < 2000) begin
            @(negedge Clock);
            cyc++;
        end
        @(negedge Clock);
        checkOutput("final_idle", 64'(Busy), 64'(0));
        checkOutput("queue_drained", 64'(expQ.size()), 64'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/multi_sensor_poller.md
MULTI_SENSOR_POLLER -- requirements
Module: multi_sensor_poller

Interface
REQ-001 Parameter NUM_CH, 2, number of sensor channels polled; legal range 1..8.
REQ-002 Parameter DATA_W, 8, width of RecData and of each stored reading.
REQ-003 Parameter ADDR_W, 8, width of each channel's chip address.
REQ-004 Parameter SETTLE_CYCLES, 16, cycles StartReading is held high per channel; minimum 1.
REQ-005 Parameter TIMEOUT_CYCLES, 1024, maximum cycles spent waiting for Done; used only with POLLER_TIMEOUT_EN.
REQ-006 Clock  input  1  single system clock; all logic on its rising edge.
REQ-007 Reset  input  1  synchronous, active-high reset.
REQ-008 Start  input  1  level; high enables continuous scanning.
REQ-009 ChipAddr  input  NUM_CH*ADDR_W  per-channel chip address; channel k occupies bits [k*ADDR_W +: ADDR_W].
REQ-010 RecData  input  DATA_W  reading returned by the serial reader.
REQ-011 Done  input  1  reader completion pulse; RecData is valid in the same cycle.
REQ-012 StartReading  output  1  request to the reader.
REQ-013 CurAddr  output  ADDR_W  address of the channel being read.
REQ-014 Temps  output  NUM_CH*DATA_W  last good reading per channel; packed like ChipAddr.
REQ-015 Valid  output  NUM_CH  per-channel flag; set when that channel's reading is fresh.
REQ-016 ScanDone  output  1  one-cycle pulse after the last channel of a scan completes.
REQ-017 Busy  output  1  high in every state except IDLE.

Function
REQ-018 The FSM SHALL have exactly these states: IDLE, LOAD, SETTLE, WAIT, STORE, NEXT; all outputs registered.
REQ-019 IDLE: Start=1 SHALL move to LOAD with channel index 0; Start=0 SHALL hold IDLE.
REQ-020 LOAD: CurAddr SHALL be set to ChipAddr[index], the settle counter SHALL be cleared, then SETTLE.
REQ-021 SETTLE: StartReading SHALL be high for exactly SETTLE_CYCLES consecutive cycles, then WAIT.
REQ-022 Done asserted in SETTLE SHALL be ignored.
REQ-023 WAIT: StartReading SHALL be 0; Done=1 SHALL move to STORE and capture RecData in the same edge.
REQ-024 STORE: Temps[index] SHALL take the captured data and Valid[index] SHALL be set to 1; other channels SHALL be unchanged.
REQ-025 NEXT: if index<NUM_CH-1, index SHALL increment and the FSM SHALL go to LOAD.
REQ-026 NEXT: if index=NUM_CH-1, ScanDone SHALL pulse for one cycle, index SHALL wrap to 0, and the FSM SHALL go to LOAD if Start=1, else IDLE.
REQ-027 Start falling mid-scan SHALL NOT abort the scan; the scan SHALL finish first, then the FSM SHALL enter IDLE.
REQ-028 With NUM_CH=1, every scan SHALL pulse ScanDone.
REQ-029 CurAddr SHALL stay stable from LOAD through STORE of the same channel.

Reset
REQ-030 Reset=1 SHALL force IDLE, index 0, StartReading 0, CurAddr 0, Temps all 0, Valid all 0, ScanDone 0, Busy 0, counters 0, from any state including mid-read.
REQ-031 Reset SHALL take priority over Start and Done in the same cycle.

Configuration
REQ-032 With POLLER_TIMEOUT_EN defined, a counter SHALL run in WAIT.
REQ-033 With POLLER_TIMEOUT_EN defined and no Done within TIMEOUT_CYCLES, Valid[index] SHALL be cleared, Temps[index] SHALL be kept, and the FSM SHALL go to NEXT.
REQ-034 With POLLER_TIMEOUT_EN defined, Done arriving in the same cycle as the timeout SHALL win, and the data SHALL be stored.
REQ-035 Without POLLER_TIMEOUT_EN, WAIT SHALL wait indefinitely for Done and no timeout counter SHALL exist.

Structure
REQ-036 Package poller_pkg SHALL hold the state encoding and the default values for SETTLE_CYCLES and TIMEOUT_CYCLES.
REQ-037 One sub-module, poll_timer, SHALL be used: a clear/count/terminal-count counter shared by the SETTLE and WAIT states.

Verification
REQ-038 NUM_CH=2, ChipAddr={8'h49,8'h48}, Start=1, Done with RecData 8'h19 then 8'h1E: required Temps={8'h1E,8'h19}, Valid=2'b11, one ScanDone pulse.
REQ-039 SETTLE_CYCLES=16: required StartReading high for exactly 16 cycles per channel; a Done pulse injected during SETTLE is ignored.
REQ-040 Start dropped during channel 0 of a 4-channel scan: required all 4 channels are read, one ScanDone pulse, then IDLE with Busy=0.
REQ-041 With the macro, TIMEOUT_CYCLES=32, channel 1 never answers: required Valid[1]=0, Temps[1] unchanged, and the scan proceeds to channel 2 after 32 WAIT cycles.
REQ-042 Reset asserted in WAIT: required all outputs 0 on the next edge; a subsequent Start restarts at channel 0.
